layer_sequencer: RTL

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_if.sv | 35 +++
 rtl/layer_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// layer_sequencer_if
// Purpose : Groups the instruction-RAM read port and the address-generator
//           handshake used by layer_sequencer.
// Signals :
//   instr_addr  - instruction RAM address (sequencer -> RAM)
//   instr_data  - Nk of the addressed layer, valid in the same cycle
//   ag_rst      - address-generator reset pulse (sequencer -> AG)
//   ag_start    - address-generator start pulse (sequencer -> AG)
//   ag_finished - layer-complete flag (AG -> sequencer)
// Modports: master = sequencer side, slave = RAM / address-generator side.
// ---------------------------------------------------------------------------
interface layer_sequencer_if;
    logic [7:0] instr_addr;
    logic [7:0] instr_data;
    logic       ag_rst;
    logic       ag_start;
    logic       ag_finished;

    modport master (
        output instr_addr,
        output ag_rst,
        output ag_start,
        input  instr_data,
        input  ag_finished
    );

    modport slave (
        input  instr_addr,
        input  ag_rst,
        input  ag_start,
        output instr_data,
        output ag_finished
    );
endinterface

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Purpose : Walks an instruction RAM of per-layer neuron counts, configures
//           and starts the address generator for each layer, waits for the
//           MAC pipeline to drain, then advances ping-pong neuron banks and
//           the weight base. A zero entry or MAX_LAYERS entries end the run.
// Ports   :
//   clk, reset        - clock, asynchronous active-high reset
//   start, n_inputs   - run request and input-layer size (sampled in IDLE)
//   bus (master)      - instruction RAM read port + address-generator handshake
//   nk, n_in          - current layer neuron count / inputs per neuron
//   neuro_read_base, neuro_write_base, weight_read_base - layer base addresses
//   busy, done        - not-idle flag, one-cycle completion pulse
//   layer_count       - layers completed in current / last run
//   wt_ovf            - sticky weight-address wrap flag
// ---------------------------------------------------------------------------
module layer_sequencer #(
    parameter int unsigned BANK_OFFSET  = 128,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MAX_LAYERS   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              n_inputs,
    layer_sequencer_if.master       bus,
    output logic [7:0]              nk,
    output logic [7:0]              n_in,
    output logic [7:0]              neuro_read_base,
    output logic [7:0]              neuro_write_base,
    output logic [7:0]              weight_read_base,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              layer_count,
    output logic                    wt_ovf
);

    localparam logic [7:0] BANK_BASE  = 8'(BANK_OFFSET);
    localparam logic [7:0] MAX_ADDR   = 8'(MAX_LAYERS);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CONFIG,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t     state_q;
    logic [7:0] addr_q;
    logic [7:0] nk_q;
    logic [7:0] n_in_q;
    logic [7:0] nrb_q;
    logic [7:0] nwb_q;
    logic [7:0] wrb_q;
    logic [7:0] drain_q;
    logic [7:0] lc_q;
    logic       ovf_q;
    logic       busy_q;
    logic       done_q;
    logic       ag_rst_q;
    logic       ag_start_q;

    // Weight-base advance computed at full width so both wrap sources are visible.
    logic [15:0] prod_d;
    logic [8:0]  wsum_d;

    assign prod_d = 16'(n_in_q) * 16'(nk_q);
    assign wsum_d = {1'b0, wrb_q} + {1'b0, prod_d[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            nk_q       <= '0;
            n_in_q     <= '0;
            nrb_q      <= '0;
            nwb_q      <= BANK_BASE;
            wrb_q      <= '0;
            drain_q    <= '0;
            lc_q       <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ag_rst_q   <= 1'b0;
            ag_start_q <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for the state it marks.
            ag_rst_q   <= 1'b0;
            ag_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= '0;
                        n_in_q  <= n_inputs;
                        wrb_q   <= '0;
                        nrb_q   <= '0;
                        nwb_q   <= BANK_BASE;
                        lc_q    <= '0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    nk_q <= bus.instr_data;
                    if (bus.instr_data == '0 || addr_q == MAX_ADDR) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ag_rst_q <= 1'b1;
                        state_q  <= CONFIG;
                    end
                end
                CONFIG: begin
                    ag_start_q <= 1'b1;
                    state_q    <= RUN;
                end
                RUN: begin
                    // ag_start_q marks the first RUN cycle; ag_finished is not
                    // sampled there, giving a minimum RUN length of two cycles.
                    if (!ag_start_q && bus.ag_finished) begin
                        drain_q <= DRAIN_LOAD;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        wrb_q   <= wsum_d[7:0];
                        ovf_q   <= ovf_q | (prod_d > 16'd255) | wsum_d[8];
                        nrb_q   <= nwb_q;
                        nwb_q   <= nrb_q;
                        n_in_q  <= nk_q;
                        addr_q  <= addr_q + 8'd1;
                        lc_q    <= lc_q + 8'd1;
                        state_q <= FETCH;
                    end else begin
                        drain_q <= drain_q - 8'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_addr   = addr_q;
    assign bus.ag_rst       = ag_rst_q;
    assign bus.ag_start     = ag_start_q;
    assign nk               = nk_q;
    assign n_in             = n_in_q;
    assign neuro_read_base  = nrb_q;
    assign neuro_write_base = nwb_q;
    assign weight_read_base = wrb_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign layer_count      = lc_q;
    assign wt_ovf           = ovf_q;

endmodule
